// File: rtl/sram_like_bridge.sv
// SRAM-style CPU fetch/data ports onto one request/ack bus, one transaction at a time, data first.
// Optional one-entry fetch buffer enabled by defining SRAM_BRIDGE_IBUF_EN.
module sram_like_bridge #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              inst_sram_en,
  input  logic [ADDR_W-1:0] inst_sram_addr,
  output logic [DATA_W-1:0] inst_sram_rdata,
  input  logic              data_sram_en,
  input  logic [DATA_W/8-1:0] data_sram_wen,
  input  logic [ADDR_W-1:0] data_sram_addr,
  input  logic [DATA_W-1:0] data_sram_wdata,
  output logic [DATA_W-1:0] data_sram_rdata,
  output logic              cpu_stall,
  output logic              mem_req,
  output logic              mem_wr,
  output logic [DATA_W/8-1:0] mem_wstrb,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_addr_ok,
  input  logic              mem_data_ok,
  input  logic [DATA_W-1:0] mem_rdata
);
  localparam int SW = DATA_W / 8;

  typedef enum logic [2:0] {IDLE, D_REQ, D_WAIT, I_REQ, I_WAIT} state_e;

  state_e            state_q;
  logic              d_done_q, i_done_q;
  logic [DATA_W-1:0] inst_rdata_q, data_rdata_q;
  logic              d_pend, i_pend, d_issue, i_issue, ibuf_hit;
  logic [DATA_W-1:0] ibuf_rdata;

  assign d_pend    = data_sram_en & ~d_done_q;
  assign i_pend    = inst_sram_en & ~i_done_q;
  assign cpu_stall = d_pend | i_pend;

  // IDLE presents the request in the same cycle it appears so that a
  // zero-wait bus gives a two-cycle fetch; REQ states hold it until addr_ok.
  assign d_issue = ~rst & ((state_q == IDLE & d_pend) | state_q == D_REQ);
  assign i_issue = ~rst & ((state_q == IDLE & ~d_pend & i_pend & ~ibuf_hit)
                           | state_q == I_REQ);

  assign mem_req   = d_issue | i_issue;
  assign mem_wr    = d_issue & (|data_sram_wen);
  assign mem_wstrb = d_issue ? data_sram_wen : '0;
  assign mem_addr  = d_issue ? data_sram_addr : (i_issue ? inst_sram_addr : '0);
  assign mem_wdata = d_issue ? data_sram_wdata : '0;

  assign inst_sram_rdata = inst_rdata_q;
  assign data_sram_rdata = data_rdata_q;

`ifdef SRAM_BRIDGE_IBUF_EN
  localparam int OFS = $clog2(SW);
  logic                  ibuf_vld_q;
  logic [ADDR_W-OFS-1:0] ibuf_tag_q;
  logic [DATA_W-1:0]     ibuf_data_q;

  assign ibuf_hit   = state_q == IDLE & ~d_pend & i_pend & ibuf_vld_q
                      & (inst_sram_addr[ADDR_W-1:OFS] == ibuf_tag_q);
  assign ibuf_rdata = ibuf_data_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ibuf_vld_q  <= 1'b0;
      ibuf_tag_q  <= '0;
      ibuf_data_q <= '0;
    end else if (state_q == I_WAIT && mem_data_ok) begin
      ibuf_vld_q  <= 1'b1;
      ibuf_tag_q  <= inst_sram_addr[ADDR_W-1:OFS];
      ibuf_data_q <= mem_rdata;
    end else if (d_issue && mem_wr && mem_addr_ok &&
                 data_sram_addr[ADDR_W-1:OFS] == ibuf_tag_q) begin
      ibuf_vld_q <= 1'b0;
    end
  end
`else
  assign ibuf_hit   = 1'b0;
  assign ibuf_rdata = '0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      d_done_q     <= 1'b0;
      i_done_q     <= 1'b0;
      inst_rdata_q <= '0;
      data_rdata_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (d_issue)      state_q <= mem_addr_ok ? D_WAIT : D_REQ;
          else if (i_issue) state_q <= mem_addr_ok ? I_WAIT : I_REQ;
          else if (ibuf_hit) begin
            i_done_q     <= 1'b1;
            inst_rdata_q <= ibuf_rdata;
          end
        end
        D_REQ: if (mem_addr_ok) state_q <= D_WAIT;
        I_REQ: if (mem_addr_ok) state_q <= I_WAIT;
        D_WAIT: if (mem_data_ok) begin
          d_done_q <= 1'b1;
          if (~|data_sram_wen) data_rdata_q <= mem_rdata;
          state_q <= IDLE;
        end
        I_WAIT: if (mem_data_ok) begin
          i_done_q     <= 1'b1;
          inst_rdata_q <= mem_rdata;
          state_q      <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
      // Advance edge: clearing wins so a result completing after en dropped is discarded.
      if (!cpu_stall) begin
        d_done_q <= 1'b0;
        i_done_q <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_sram_like_bridge.sv
// Directed bench for sram_like_bridge; bus handshakes driven cycle by cycle.
module tb_sram_like_bridge;
  logic        clk = 1'b0;
  logic        rst;
  logic        inst_sram_en;
  logic [31:0] inst_sram_addr;
  logic [31:0] inst_sram_rdata;
  logic        data_sram_en;
  logic [3:0]  data_sram_wen;
  logic [31:0] data_sram_addr;
  logic [31:0] data_sram_wdata;
  logic [31:0] data_sram_rdata;
  logic        cpu_stall;
  logic        mem_req;
  logic        mem_wr;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_addr_ok;
  logic        mem_data_ok;
  logic [31:0] mem_rdata;

  int n_run = 0;
  int n_fail = 0;
  int n_acc = 0;

  sram_like_bridge #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .rst(rst),
    .inst_sram_en(inst_sram_en), .inst_sram_addr(inst_sram_addr),
    .inst_sram_rdata(inst_sram_rdata),
    .data_sram_en(data_sram_en), .data_sram_wen(data_sram_wen),
    .data_sram_addr(data_sram_addr), .data_sram_wdata(data_sram_wdata),
    .data_sram_rdata(data_sram_rdata),
    .cpu_stall(cpu_stall),
    .mem_req(mem_req), .mem_wr(mem_wr), .mem_wstrb(mem_wstrb),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_addr_ok(mem_addr_ok), .mem_data_ok(mem_data_ok), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (!rst && mem_req && mem_addr_ok) n_acc <= n_acc + 1;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic bus(input logic aok, input logic dok, input logic [31:0] rd);
    mem_addr_ok = aok;
    mem_data_ok = dok;
    mem_rdata   = rd;
  endtask

  int acc0;

  initial begin
    rst = 1'b1;
    inst_sram_en = 0; inst_sram_addr = 0;
    data_sram_en = 0; data_sram_wen = 0; data_sram_addr = 0; data_sram_wdata = 0;
    bus(0, 0, 0);
    tick(); tick();
    chk("rst_stall", cpu_stall, 0);
    chk("rst_req", mem_req, 0);
    chk("rst_addr", mem_addr, 0);
    chk("rst_irdata", inst_sram_rdata, 0);
    chk("rst_drdata", data_sram_rdata, 0);
    rst = 1'b0;
    tick();

    // single fetch, zero-wait bus
    acc0 = n_acc;
    inst_sram_en = 1; inst_sram_addr = 32'hBFC0_0000;
    bus(1, 0, 0); #1;
    chk("f_stall0", cpu_stall, 1);
    chk("f_req0", mem_req, 1);
    chk("f_wr0", mem_wr, 0);
    chk("f_addr0", mem_addr, 32'hBFC0_0000);
    tick();
    bus(0, 1, 32'h2401_0001); #1;
    chk("f_req1", mem_req, 0);
    chk("f_stall1", cpu_stall, 1);
    tick();
    bus(0, 0, 0); #1;
    chk("f_stall2", cpu_stall, 0);
    chk("f_rdata", inst_sram_rdata, 32'h2401_0001);
    chk("f_nacc", n_acc - acc0, 1);
    tick();
    inst_sram_en = 0;
    tick();

    // store + fetch in one cycle: data first, 4 stall cycles
    inst_sram_en = 1; inst_sram_addr = 32'h200;
    data_sram_en = 1; data_sram_wen = 4'b0011;
    data_sram_addr = 32'h8000_0010; data_sram_wdata = 32'hDEAD_BEEF;
    bus(1, 0, 0); #1;
    chk("sf_req0", mem_req, 1);
    chk("sf_wr0", mem_wr, 1);
    chk("sf_strb0", mem_wstrb, 4'b0011);
    chk("sf_addr0", mem_addr, 32'h8000_0010);
    chk("sf_wdata0", mem_wdata, 32'hDEAD_BEEF);
    tick();
    bus(0, 1, 32'h1234_5678); #1;
    chk("sf_req1", mem_req, 0);
    tick();
    bus(1, 0, 0); #1;
    chk("sf_req2", mem_req, 1);
    chk("sf_wr2", mem_wr, 0);
    chk("sf_addr2", mem_addr, 32'h200);
    chk("sf_strb2", mem_wstrb, 0);
    chk("sf_stall2", cpu_stall, 1);
    tick();
    bus(0, 1, 32'h1111_1111); #1;
    chk("sf_stall3", cpu_stall, 1);
    tick();
    bus(0, 0, 0); #1;
    chk("sf_stall4", cpu_stall, 0);
    chk("sf_drdata", data_sram_rdata, 0);
    chk("sf_irdata", inst_sram_rdata, 32'h1111_1111);
    tick();
    inst_sram_en = 0; data_sram_en = 0; data_sram_wen = 0;
    tick();

    // back-pressure on a load
    acc0 = n_acc;
    data_sram_en = 1; data_sram_addr = 32'h40; data_sram_wdata = 32'hCAFE_F00D;
    for (int c = 0; c < 3; c++) begin
      bus(0, 0, 0); #1;
      chk($sformatf("bp_req%0d", c), mem_req, 1);
      chk($sformatf("bp_addr%0d", c), mem_addr, 32'h40);
      chk($sformatf("bp_wdata%0d", c), mem_wdata, 32'hCAFE_F00D);
      tick();
    end
    bus(1, 0, 0); #1;
    chk("bp_req3", mem_req, 1);
    tick();
    bus(0, 1, 32'hA5A5_A5A5); #1;
    chk("bp_req4", mem_req, 0);
    tick();
    bus(0, 0, 0); #1;
    chk("bp_stall", cpu_stall, 0);
    chk("bp_drdata", data_sram_rdata, 32'hA5A5_A5A5);
    chk("bp_nacc", n_acc - acc0, 1);
    tick();
    data_sram_en = 0;
    tick();

    // back-to-back fetches
    inst_sram_en = 1; inst_sram_addr = 32'h100;
    bus(1, 0, 0); tick();
    bus(0, 1, 32'h0000_AAAA); tick();
    bus(0, 0, 0); #1;
    chk("bb_stall_a", cpu_stall, 0);
    chk("bb_rdata_a", inst_sram_rdata, 32'h0000_AAAA);
    tick();
    inst_sram_addr = 32'h104;
    bus(1, 0, 0); #1;
    chk("bb_stall_b", cpu_stall, 1);
    chk("bb_req_b", mem_req, 1);
    chk("bb_addr_b", mem_addr, 32'h104);
    tick();
    bus(0, 1, 32'h0000_BBBB); tick();
    bus(0, 0, 0); #1;
    chk("bb_stall_c", cpu_stall, 0);
    chk("bb_rdata_b", inst_sram_rdata, 32'h0000_BBBB);
    tick();
    inst_sram_en = 0;
    tick();

    // reset while in D_WAIT
    data_sram_en = 1; data_sram_addr = 32'h80;
    bus(1, 0, 0); tick();
    bus(0, 0, 0); #1;
    chk("rw_req_wait", mem_req, 0);
    rst = 1'b1; #1;
    chk("rw_req_rst", mem_req, 0);
    chk("rw_drdata", data_sram_rdata, 0);
    chk("rw_irdata", inst_sram_rdata, 0);
    tick();
    rst = 1'b0; #1;
    chk("rw_req_new", mem_req, 1);
    chk("rw_addr_new", mem_addr, 32'h80);
    bus(1, 0, 0); tick();
    bus(0, 1, 32'h5555_0000); tick();
    bus(0, 0, 0); #1;
    chk("rw_stall", cpu_stall, 0);
    chk("rw_drdata2", data_sram_rdata, 32'h5555_0000);
    tick();
    data_sram_en = 0;
    tick();

`ifdef SRAM_BRIDGE_IBUF_EN
    // fill the buffer with 0x100, then refetch from it
    inst_sram_en = 1; inst_sram_addr = 32'h100;
    bus(1, 0, 0); tick();
    bus(0, 1, 32'h0000_CCCC); tick();
    bus(0, 0, 0); tick();
    inst_sram_en = 0; tick();
    acc0 = n_acc;
    inst_sram_en = 1; #1;
    chk("ib_hit_req", mem_req, 0);
    chk("ib_hit_stall", cpu_stall, 1);
    tick();
    chk("ib_hit_stall1", cpu_stall, 0);
    chk("ib_hit_rdata", inst_sram_rdata, 32'h0000_CCCC);
    chk("ib_hit_nacc", n_acc - acc0, 0);
    tick();
    inst_sram_en = 0; tick();
    // store to the buffered word invalidates it
    data_sram_en = 1; data_sram_wen = 4'b1111; data_sram_addr = 32'h100;
    bus(1, 0, 0); tick();
    bus(0, 1, 0); tick();
    bus(0, 0, 0); tick();
    data_sram_en = 0; data_sram_wen = 0; tick();
    inst_sram_en = 1; #1;
    chk("ib_miss_req", mem_req, 1);
    bus(1, 0, 0); tick();
    bus(0, 1, 32'h0000_DDDD); tick();
    bus(0, 0, 0); #1;
    chk("ib_miss_rdata", inst_sram_rdata, 32'h0000_DDDD);
    tick();
    inst_sram_en = 0; tick();
`endif

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
